pipeline_regfile: RTL and testbench

PIPELINE_REGFILE -- requirements
Module: pipeline_regfile

---
 rtl/pipeline_regfile.sv | 190 +++++++++++++++++++
 tb/tb_pipeline_regfile.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_regfile.sv
// pipeline_regfile -- architectural register file with an issue/writeback
// scoreboard and a stack-pointer based end-of-program detector.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> a read that hits the same-cycle writeback returns data_rd
//   undefined -> reads return stored values only
//
// Ports:
//   clock, reset             rising-edge clock, async active-high reset
//   addr_rs1/addr_rs2        read addresses
//   data_rs1/data_rs2        combinational read data
//   rs1_busy/rs2_busy        stored busy bit of the addressed register
//   write_enable/addr_rd/data_rd   writeback port
//   issue_valid/issue_rd     marks issue_rd busy on the next edge
//   pending_count            population count of busy bits (registered)
//   halt                     sticky end-of-program flag

// One architectural register plus its scoreboard bit.
module regfile_entry #(
    parameter int              XLEN    = 32,
    parameter logic [XLEN-1:0] RST_VAL = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_data,
    input  logic            set_busy,
    input  logic            clr_busy,
    output logic [XLEN-1:0] value,
    output logic            busy,
    output logic            busy_next
);
    // Issue takes priority over writeback so a same-cycle reissue keeps
    // the register reserved for the younger instruction.
    assign busy_next = set_busy | (busy & ~clr_busy);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= RST_VAL;
            busy  <= 1'b0;
        end else begin
            if (wr_en)
                value <= wr_data;
            busy <= busy_next;
        end
    end
endmodule

module pipeline_regfile #(
    parameter int                XLEN    = 32,
    parameter int                NREGS   = 32,
    parameter int                SP_IDX  = 2,
    parameter logic [XLEN-1:0]   SP_INIT = 32'h0100_0000,
    parameter int                AW      = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   addr_rs1,
    input  logic [AW-1:0]   addr_rs2,
    output logic [XLEN-1:0] data_rs1,
    output logic [XLEN-1:0] data_rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            write_enable,
    input  logic [AW-1:0]   addr_rd,
    input  logic [XLEN-1:0] data_rd,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic [AW:0]     pending_count,
    output logic            halt
);
    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           busy;
    logic [NREGS-1:0]           busy_nxt;

    // Register storage: x0 is hard-wired, every other index gets an entry.
    genvar i;
    generate
        for (i = 0; i < NREGS; i++) begin : g_reg
            if (i == 0) begin : g_zero
                assign regs[i]     = '0;
                assign busy[i]     = 1'b0;
                assign busy_nxt[i] = 1'b0;
            end else begin : g_ent
                logic wr_hit;
                logic is_hit;
                assign wr_hit = write_enable && (addr_rd == AW'(i));
                assign is_hit = issue_valid  && (issue_rd == AW'(i));
                regfile_entry #(
                    .XLEN    (XLEN),
                    .RST_VAL ((i == SP_IDX) ? SP_INIT : {XLEN{1'b0}})
                ) u_ent (
                    .clock     (clock),
                    .reset     (reset),
                    .wr_en     (wr_hit),
                    .wr_data   (data_rd),
                    .set_busy  (is_hit),
                    .clr_busy  (wr_hit),
                    .value     (regs[i]),
                    .busy      (busy[i]),
                    .busy_next (busy_nxt[i])
                );
            end
        end
    endgenerate

    // pending_count is registered from the next-state busy vector so it
    // always matches busy[] on the same edge.
    logic [AW:0] cnt_nxt;
    always_comb begin
        cnt_nxt = '0;
        for (int k = 0; k < NREGS; k++)
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[k]};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            pending_count <= '0;
        else
            pending_count <= cnt_nxt;
    end

    // Read ports
    logic wb_live;
    assign wb_live = write_enable && (addr_rd != '0);

    always_comb begin
        data_rs1 = regs[addr_rs1];
        data_rs2 = regs[addr_rs2];
`ifdef REGFILE_BYPASS_EN
        if (wb_live && (addr_rd == addr_rs1))
            data_rs1 = data_rd;
        if (wb_live && (addr_rd == addr_rs2))
            data_rs2 = data_rd;
`endif
    end

    assign rs1_busy = busy[addr_rs1];
    assign rs2_busy = busy[addr_rs2];

    // Halt detector: the first SP write (the prologue's adjust) arms it,
    // a later write restoring SP to its reset value marks program end.
    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_HALTED
    } state_t;

    state_t state;
    logic   sp_wr;
    logic   sp_restore;

    assign sp_wr      = wb_live && (addr_rd == AW'(SP_IDX));
    assign sp_restore = sp_wr && (data_rd == SP_INIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            halt  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sp_wr)
                        state <= S_ARMED;
                    halt <= 1'b0;
                end
                S_ARMED: begin
                    if (sp_restore) begin
                        state <= S_HALTED;
                        halt  <= 1'b1;
                    end else begin
                        halt  <= 1'b0;
                    end
                end
                S_HALTED: begin
                    state <= S_HALTED;
                    halt  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    halt  <= 1'b0;
                end
            endcase
        end
    end

    // Unused by the datapath when the bypass is compiled out.
    logic unused_wb;
    assign unused_wb = wb_live;
endmodule

// File: tb/tb_pipeline_regfile.sv
// Testbench for pipeline_regfile: directed scenarios followed by random
// traffic. Each cycle the driver pushes the expected outputs computed from
// a behavioural model; a monitor pops and compares on the falling edge.
module tb_pipeline_regfile;
    localparam logic [31:0] SP_INIT = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  addr_rs1 = '0, addr_rs2 = '0, addr_rd = '0, issue_rd = '0;
    logic [31:0] data_rs1, data_rs2, data_rd = '0;
    logic        rs1_busy, rs2_busy, halt;
    logic        write_enable = 1'b0, issue_valid = 1'b0;
    logic [5:0]  pending_count;

    pipeline_regfile dut (
        .clock(clk), .reset(reset),
        .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
        .data_rs1(data_rs1), .data_rs2(data_rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .write_enable(write_enable), .addr_rd(addr_rd), .data_rd(data_rd),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .pending_count(pending_count), .halt(halt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural state as plain arrays.
    logic [31:0] mreg [32];
    bit          mbusy[32];
    int          mphase;     // 0 = not armed, 1 = armed, 2 = halted

    function automatic void model_reset();
        for (int k = 0; k < 32; k++) begin
            mreg[k]  = '0;
            mbusy[k] = 1'b0;
        end
        mreg[2] = SP_INIT;
        mphase  = 0;
    endfunction

    function automatic void model_edge(bit we, int rd, logic [31:0] d, bit iv, int ird);
        if (we && rd != 0) begin
            mreg[rd]  = d;
            mbusy[rd] = 1'b0;
            if (rd == 2) begin
                if (mphase == 0) mphase = 1;
                else if (mphase == 1 && d == SP_INIT) mphase = 2;
            end
        end
        if (iv && ird != 0) mbusy[ird] = 1'b1;
    endfunction

    function automatic logic [31:0] model_read(int a, bit we, int rd, logic [31:0] d);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && rd == a) return d;
`endif
        return mreg[a];
    endfunction

    typedef struct {
        logic [31:0] d1, d2;
        bit          b1, b2;
        int          cnt;
        bit          h;
    } exp_t;

    exp_t q[$];

    // One clock: the edge applies the previously driven inputs to the
    // model, then new inputs are driven and their expectation queued.
    task automatic cycle(input bit we, input int rd, input logic [31:0] d,
                         input bit iv, input int ird, input int a1, input int a2);
        exp_t e;
        int   c;
        @(posedge clk);
        if (!reset)
            model_edge(write_enable, int'(addr_rd), data_rd, issue_valid, int'(issue_rd));
        #1;
        write_enable = we;  addr_rd = 5'(rd);  data_rd = d;
        issue_valid  = iv;  issue_rd = 5'(ird);
        addr_rs1 = 5'(a1);  addr_rs2 = 5'(a2);
        c = 0;
        for (int k = 0; k < 32; k++) c += int'(mbusy[k]);
        e.d1  = model_read(a1, we, rd, d);
        e.d2  = model_read(a2, we, rd, d);
        e.b1  = mbusy[a1];
        e.b2  = mbusy[a2];
        e.cnt = c;
        e.h   = (mphase == 2);
        q.push_back(e);
    endtask

    task automatic idle(input int a1, input int a2);
        cycle(1'b0, 0, 32'h0, 1'b0, 0, a1, a2);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("data_rs1", data_rs1, e.d1);
                chk("data_rs2", data_rs2, e.d2);
                chk("rs1_busy", 32'(rs1_busy), 32'(e.b1));
                chk("rs2_busy", 32'(rs2_busy), 32'(e.b2));
                chk("pending_count", 32'(pending_count), 32'(e.cnt));
                chk("halt", 32'(halt), 32'(e.h));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset contents of every register.
        for (int a = 0; a < 32; a++) idle(a, 31 - a);

        // Write x5, same-cycle read and next-cycle read.
        cycle(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 5, 0);
        idle(5, 2);

        // x0 is immune to writes and issue.
        cycle(1'b1, 0, 32'hFFFF_FFFF, 1'b1, 0, 0, 5);
        idle(0, 0);

        // Scoreboard set/clear and set-wins.
        cycle(1'b0, 0, 0, 1'b1, 7, 7, 9);
        cycle(1'b0, 0, 0, 1'b1, 9, 7, 9);
        idle(7, 9);
        cycle(1'b1, 7, 32'h1234_5678, 1'b1, 7, 7, 9);
        idle(7, 9);
        cycle(1'b1, 9, 32'hA5A5_A5A5, 1'b0, 0, 7, 9);
        idle(7, 9);

        // Halt sequence on the stack pointer.
        cycle(1'b1, 2, SP_INIT, 1'b0, 0, 2, 0);
        idle(2, 0);
        cycle(1'b1, 2, 32'h00FF_FFF0, 1'b0, 0, 2, 0);
        cycle(1'b1, 2, SP_INIT, 1'b0, 0, 2, 0);
        idle(2, 0);
        cycle(1'b1, 4, 32'h0000_0044, 1'b1, 3, 3, 2);
        idle(3, 2);

        // Asynchronous reset in the middle of a cycle, with live traffic
        // that must be discarded.
        @(posedge clk);
        model_edge(write_enable, int'(addr_rd), data_rd, issue_valid, int'(issue_rd));
        #1;
        write_enable = 1'b1; addr_rd = 5'd5; data_rd = 32'hCAFE_F00D;
        issue_valid  = 1'b1; issue_rd = 5'd4;
        addr_rs1 = 5'd3; addr_rs2 = 5'd2;
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_count", 32'(pending_count), 32'd0);
        chk("rst_busy_x3", 32'(rs1_busy), 32'd0);
        chk("rst_x3", data_rs1, 32'd0);
        chk("rst_sp", data_rs2, SP_INIT);
        repeat (2) @(posedge clk);
        @(negedge clk);
        write_enable = 1'b0; issue_valid = 1'b0; addr_rd = '0; issue_rd = '0;
        reset = 1'b0;
        idle(5, 4);
        idle(4, 7);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            bit          we, iv;
            int          rd, ird;
            logic [31:0] d;
            we  = 1'($urandom_range(0, 1));
            iv  = 1'($urandom_range(0, 1));
            rd  = ($urandom_range(0, 5) == 0) ? 2 : int'($urandom_range(0, 31));
            ird = int'($urandom_range(0, 31));
            d   = ($urandom_range(0, 2) == 0) ? SP_INIT : 32'($urandom);
            cycle(we, rd, d, iv, ird,
                  ($urandom_range(0, 3) == 0) ? rd : int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)));
        end
        idle(0, 0);

        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
